// File: rtl/apb_pkg.sv
// Shared types for the APB initiator bridge.
//   apb_mst_state_e : bridge FSM state encoding
//   apb_req_t       : latched request (write, addr, wdata) sized by the
//                     package width constants; instance widths must not
//                     exceed these.
package apb_pkg;
  localparam int APB_ADDR_WIDTH_DEF = 32;
  localparam int APB_DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic                          write;
    logic [APB_ADDR_WIDTH_DEF-1:0] addr;
    logic [APB_DATA_WIDTH_DEF-1:0] wdata;
  } apb_req_t;
endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait-state counter.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (start of a transfer)
//   en       : count one wait state
//   expired  : counter has reached TIMEOUT_CYCLES-1; constant 0 when
//              TIMEOUT_CYCLES is 0 (timeout disabled)
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      logic [CW-1:0] cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
      end
      assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate
endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready request -> APB SETUP/ACCESS
// -> valid/ready response, with an optional ACCESS-phase timeout.
//   REQ_*  : request channel (accepted in IDLE only)
//   RSP_*  : response channel (held in RESP until RSP_READY_i)
//   P*     : APB initiator port
//   BUSY_o : high whenever a transfer or response is in flight
// All outputs come from registers or state decode; no input reaches an
// output combinationally.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK_i,
  input  logic                      ARESET_i,
  input  logic                      REQ_VALID_i,
  output logic                      REQ_READY_o,
  input  logic                      REQ_WRITE_i,
  input  logic [APB_ADDR_WIDTH-1:0] REQ_ADDR_i,
  input  logic [APB_DATA_WIDTH-1:0] REQ_WDATA_i,
  output logic                      RSP_VALID_o,
  input  logic                      RSP_READY_i,
  output logic [APB_DATA_WIDTH-1:0] RSP_RDATA_o,
  output logic                      RSP_ERR_o,
  output logic                      RSP_TIMEOUT_o,
  output logic                      PSEL_o,
  output logic                      PENABLE_o,
  output logic                      PWRITE_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
  output logic [APB_DATA_WIDTH-1:0] PWDATA_o,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA_i,
  input  logic                      PREADY_i,
  input  logic                      PSLVERR_i,
  output logic                      BUSY_o
);
  apb_mst_state_e state_q, state_d;
  apb_req_t       req_q;
  logic           req_ld, cnt_clr, cnt_en, rsp_ld, rsp_to, to_expired;

  apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_to (
    .clk     (ACLK_i),
    .rst     (ARESET_i),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (to_expired)
  );

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req_ld  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    rsp_ld  = 1'b0;
    rsp_to  = 1'b0;
    case (state_q)
      ST_IDLE: if (REQ_VALID_i) begin
        req_ld  = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // PREADY has priority over a timeout in the same cycle
        if (PREADY_i) begin
          rsp_ld  = 1'b1;
          state_d = ST_RESP;
        end else if (to_expired) begin
          rsp_ld  = 1'b1;
          rsp_to  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: if (RSP_READY_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request register: write data is zeroed for reads so PWDATA reads as 0.
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      req_q <= '0;
    end else if (req_ld) begin
      req_q.write <= REQ_WRITE_i;
      req_q.addr  <= APB_ADDR_WIDTH_DEF'(REQ_ADDR_i);
      req_q.wdata <= REQ_WRITE_i ? APB_DATA_WIDTH_DEF'(REQ_WDATA_i) : '0;
    end
  end

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      RSP_RDATA_o   <= '0;
      RSP_ERR_o     <= 1'b0;
      RSP_TIMEOUT_o <= 1'b0;
    end else if (rsp_ld) begin
      RSP_ERR_o     <= rsp_to | PSLVERR_i;
      RSP_TIMEOUT_o <= rsp_to;
      RSP_RDATA_o   <= (!rsp_to && !PSLVERR_i && !req_q.write) ? PRDATA_i : '0;
    end
  end

  assign REQ_READY_o = (state_q == ST_IDLE);
  assign BUSY_o      = (state_q != ST_IDLE);
  assign PSEL_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE_o   = (state_q == ST_ACCESS);
  assign RSP_VALID_o = (state_q == ST_RESP);
  assign PWRITE_o    = req_q.write;
  assign PADDR_o     = APB_ADDR_WIDTH'(req_q.addr);
  assign PWDATA_o    = APB_DATA_WIDTH'(req_q.wdata);
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a 4-cycle timeout; the APB
// slave side is driven by hand in each step.
module tb_apb_master_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr, busy;

  int total = 0;
  int passed = 0;

  apb_master_bridge #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .ACLK_i(clk), .ARESET_i(rst),
    .REQ_VALID_i(req_valid), .REQ_READY_o(req_ready), .REQ_WRITE_i(req_write),
    .REQ_ADDR_i(req_addr), .REQ_WDATA_i(req_wdata),
    .RSP_VALID_o(rsp_valid), .RSP_READY_i(rsp_ready), .RSP_RDATA_o(rsp_rdata),
    .RSP_ERR_o(rsp_err), .RSP_TIMEOUT_o(rsp_timeout),
    .PSEL_o(psel), .PENABLE_o(penable), .PWRITE_o(pwrite),
    .PADDR_o(paddr), .PWDATA_o(pwdata), .PRDATA_i(prdata),
    .PREADY_i(pready), .PSLVERR_i(pslverr), .BUSY_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns after the accepting edge (SETUP).
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    chk1("req_ready_idle", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; prdata = 0; pready = 0; pslverr = 0;
    #12;
    // reset state
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_psel", psel, 1'b0);
    chk1("rst_penable", penable, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_paddr", paddr, 32'h0);
    chk32("rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk); rst = 1'b0;
    step();

    // zero-wait write
    pready = 1'b1; rsp_ready = 1'b1;
    issue(1'b1, 32'h1A10_0004, 32'hDEAD_BEEF);
    chk1("wr_setup_psel", psel, 1'b1);
    chk1("wr_setup_pen", penable, 1'b0);
    chk1("wr_pwrite", pwrite, 1'b1);
    chk32("wr_paddr", paddr, 32'h1A10_0004);
    chk32("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    chk1("wr_busy", busy, 1'b1);
    step();
    chk1("wr_access_psel", psel, 1'b1);
    chk1("wr_access_pen", penable, 1'b1);
    step();
    chk1("wr_rsp_valid", rsp_valid, 1'b1);
    chk1("wr_rsp_psel", psel, 1'b0);
    chk1("wr_rsp_err", rsp_err, 1'b0);
    chk32("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk1("wr_rsp_noready", req_ready, 1'b0);
    step();
    chk1("wr_back_idle", req_ready, 1'b1);
    chk1("wr_rsp_drop", rsp_valid, 1'b0);
    chk32("wr_paddr_hold", paddr, 32'h1A10_0004);

    // read with 3 wait states; PREADY coincides with the timeout cycle
    pready = 1'b0; prdata = 32'h1234_5678;
    issue(1'b0, 32'h1A10_0008, 32'hAAAA_AAAA);
    chk32("rd_pwdata_zero", pwdata, 32'h0);
    chk1("rd_pwrite", pwrite, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk1("rd_access_pen", penable, 1'b1);
      chk32("rd_paddr_stable", paddr, 32'h1A10_0008);
      chk1("rd_no_rsp", rsp_valid, 1'b0);
      if (i == 3) pready = 1'b1;
      step();
    end
    pready = 1'b0;
    chk1("rd_rsp_valid", rsp_valid, 1'b1);
    chk32("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk1("rd_rsp_err", rsp_err, 1'b0);
    chk1("rd_rsp_to", rsp_timeout, 1'b0);
    step();

    // read with PSLVERR
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
    issue(1'b0, 32'h1A10_000C, 32'h0);
    step();
    step();
    pslverr = 1'b0;
    chk1("se_rsp_valid", rsp_valid, 1'b1);
    chk1("se_rsp_err", rsp_err, 1'b1);
    chk1("se_rsp_to", rsp_timeout, 1'b0);
    chk32("se_rsp_rdata", rsp_rdata, 32'h0);
    step();

    // timeout: PREADY never comes, 4 ACCESS cycles then abort
    pready = 1'b0; prdata = 32'h5555_5555;
    issue(1'b0, 32'h1A10_0010, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk1("to_access_pen", penable, 1'b1);
      step();
    end
    chk1("to_psel_drop", psel, 1'b0);
    chk1("to_pen_drop", penable, 1'b0);
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_rsp_err", rsp_err, 1'b1);
    chk1("to_rsp_to", rsp_timeout, 1'b1);
    chk32("to_rsp_rdata", rsp_rdata, 32'h0);
    chk32("to_paddr_hold", paddr, 32'h1A10_0010);
    step();

    // response backpressure with a pending request
    pready = 1'b1; rsp_ready = 1'b0; prdata = 32'hCAFE_F00D;
    issue(1'b0, 32'h1A10_0014, 32'h0);
    step();
    step();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1A10_0018; req_wdata = 32'h0BAD_CAFE;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk32("bp_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
      chk1("bp_req_ready", req_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk1("bp_accept_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    chk1("bp_next_setup", psel, 1'b1);
    chk32("bp_next_paddr", paddr, 32'h1A10_0018);
    chk32("bp_next_pwdata", pwdata, 32'h0BAD_CAFE);
    step();
    step();
    chk1("bp_next_rsp", rsp_valid, 1'b1);
    step();

    // async reset during ACCESS
    pready = 1'b0;
    issue(1'b0, 32'h1A10_001C, 32'h0);
    step();
    chk1("ar_in_access", penable, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("ar_psel", psel, 1'b0);
    chk1("ar_penable", penable, 1'b0);
    chk1("ar_rsp_valid", rsp_valid, 1'b0);
    chk1("ar_req_ready", req_ready, 1'b1);
    chk32("ar_paddr", paddr, 32'h0);
    @(negedge clk); rst = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("ar_no_rsp", rsp_valid, 1'b0);
      chk1("ar_idle", busy, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB initiator: converts a valid/ready request/response interface from an internal master (core, DMA, debug unit) into APB SETUP/ACCESS transfers. It drives the slave port of `apb_node`, which then decodes and fans out to the peripherals. A programmable wait-state timeout terminates transfers to slaves that never assert PREADY and returns an error response.

## Interface
- `APB_ADDR_WIDTH`, 32, width of PADDR and request address
- `APB_DATA_WIDTH`, 32, width of PWDATA/PRDATA and request/response data
- `TIMEOUT_CYCLES`, 256, ACCESS-phase cycles allowed before abort; 0 disables the timeout
- Clock and reset: one clock; reset is asynchronous and active-high.
- `ACLK_i`  in  1  clock
- `ARESET_i`  in  1  asynchronous reset, active-high
- `REQ_VALID_i`  in  1  request valid
- `REQ_READY_o`  out  1  request accepted when high with REQ_VALID_i
- `REQ_WRITE_i`  in  1  1 = write, 0 = read
- `REQ_ADDR_i`  in  APB_ADDR_WIDTH  transfer address
- `REQ_WDATA_i`  in  APB_DATA_WIDTH  write data
- `RSP_VALID_o`  out  1  response valid
- `RSP_READY_i`  in  1  response consumed
- `RSP_RDATA_o`  out  APB_DATA_WIDTH  read data; 0 for writes and errors
- `RSP_ERR_o`  out  1  PSLVERR captured or timeout
- `RSP_TIMEOUT_o`  out  1  error caused by timeout
- `PSEL_o`, `PENABLE_o`, `PWRITE_o`  out  1 each  APB control
- `PADDR_o`  out  APB_ADDR_WIDTH  APB address
- `PWDATA_o`  out  APB_DATA_WIDTH  APB write data
- `PRDATA_i`  in  APB_DATA_WIDTH  APB read data
- `PREADY_i`, `PSLVERR_i`  in  1 each  APB completion/error
- `BUSY_o`  out  1  high in every state except IDLE

## Operation
- FSM states IDLE, SETUP, ACCESS, RESP.
- IDLE: REQ_READY_o = 1. On REQ_VALID_i, register write/addr/wdata, go SETUP.
- SETUP: PSEL_o = 1, PENABLE_o = 0; unconditionally go ACCESS.
- ACCESS: PSEL_o = 1, PENABLE_o = 1; wait-state counter increments each cycle PREADY_i = 0.
  - PREADY_i = 1: capture PSLVERR_i into RSP_ERR_o; capture PRDATA_i into RSP_RDATA_o for reads with PSLVERR_i = 0, else 0; go RESP.
  - No PREADY_i and counter = TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES > 0): RSP_ERR_o = 1, RSP_TIMEOUT_o = 1, RSP_RDATA_o = 0; go RESP.
  - PREADY_i wins if it coincides with the timeout cycle.
- RESP: PSEL_o = PENABLE_o = 0; RSP_VALID_o = 1, response held stable until RSP_READY_i; then IDLE (no REQ_READY_o in RESP).
- PADDR_o, PWRITE_o and PWDATA_o are driven from the request register and stay stable from SETUP through the last ACCESS cycle. PWDATA_o is 0 for reads. All three hold their last values in RESP and IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It is cleared on entry to SETUP.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-transfer): state IDLE; all outputs 0 except REQ_READY_o = 1; request and response registers and counter cleared. A transfer cut by reset is dropped with no response.
- Zero-wait-state transfer: request accepted at cycle 0, SETUP at 1, ACCESS with PREADY at 2, RSP_VALID_o at 3. The earliest next accept is at cycle 4 if RSP_READY_i is high at 3.
- Each PREADY_i = 0 cycle in ACCESS adds one cycle.
- Throughput: at most one transfer per 4 cycles.
- All outputs are registered or decoded from state only. No input-to-output combinational path.

## Structure
- `apb_pkg`: state enum typedef `apb_mst_state_e`, and a request struct (write, addr, wdata) parameterised by the widths through package constants `APB_ADDR_WIDTH_DEF`/`APB_DATA_WIDTH_DEF`.
- One sub-module, `apb_timeout_cnt` (clear, enable, expired output, TIMEOUT_CYCLES parameter, tied off when 0).

## Test plan
- Write 0x1A10_0004 ← 0xDEAD_BEEF, PREADY = 1 immediately -> PSEL rises at cycle 1 and PENABLE at cycle 2. RSP_VALID at cycle 3 with ERR = 0 and RDATA = 0.
- Read 0x1A10_0008, 3 wait states, PRDATA = 0x1234_5678 -> ACCESS lasts 4 cycles and PADDR is stable throughout. RSP_RDATA = 0x1234_5678.
- Read with PSLVERR = 1, PRDATA = 0xFFFF_FFFF -> RSP_ERR = 1, RSP_TIMEOUT = 0, RSP_RDATA = 0.
- TIMEOUT_CYCLES = 4, PREADY held 0 -> PSEL/PENABLE drop after 4 ACCESS cycles. RSP_ERR = 1 and RSP_TIMEOUT = 1. PREADY on the 4th cycle instead -> normal response.
- RSP_READY held 0 for 5 cycles with REQ_VALID high -> response stable, REQ_READY = 0. Next request accepted the cycle after the handshake.
- ARESET asserted during ACCESS -> PSEL, PENABLE and RSP_VALID = 0 immediately and REQ_READY = 1. No response is issued after release.
